// File: rtl/mips_pkg.sv
// Shared types and constants for the data-memory bus controller.
// Used by mem_bus_ctrl and its optional bus_timeout_cnt (BUS_TIMEOUT_EN).
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0]  WORD_ALIGN_MASK = 2'b11;
  localparam logic [31:0] ERR_DATA        = 32'hFFFF_FFFF;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Watchdog for a pending bus transaction.
// Instantiated by mem_bus_ctrl only when BUS_TIMEOUT_EN is defined.
module bus_timeout_cnt #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // Fires in the TIMEOUT-th WAIT cycle, counting the first as zero.
  assign expired = en && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_ctrl.sv
// Multi-cycle data-memory controller: MEM-stage loads/stores over req/ack.
// Define BUS_TIMEOUT_EN to add the WAIT watchdog and the sticky BusErr output.
module mem_bus_ctrl
  import mips_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
`ifdef BUS_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [ADDR_W-1:0] ALUOutM,
  input  logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] ReadDataM,
  output logic              StallMem,
  output logic              MisalignM,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
`ifdef BUS_TIMEOUT_EN
  ,
  output logic              BusErr
`endif
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic              mis_q, mis_d;
  logic              mem_req;
  logic              misal;
  logic              accept;

  assign mem_req = MemReadM | MemWriteM;
  assign misal   = |(ALUOutM[1:0] & WORD_ALIGN_MASK);
  assign accept  = (state_q == IDLE) && mem_req && !misal;

`ifdef BUS_TIMEOUT_EN
  logic to_hit;
  logic err_q, err_d;

  bus_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (9)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (state_q == WAIT),
    .expired (to_hit)
  );
`endif

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    req_d   = req_q;
    we_d    = we_q;
    mis_d   = 1'b0;
`ifdef BUS_TIMEOUT_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (mem_req && misal) begin
          mis_d   = 1'b1;
          rdata_d = '0;
        end else if (accept) begin
          state_d = WAIT;
          req_d   = 1'b1;
          we_d    = MemWriteM;
          addr_d  = {ALUOutM[ADDR_W-1:2], 2'b00};
          wdata_d = WriteDataM;
        end
      end
      WAIT: begin
        if (bus_ack) begin
          if (!we_q)
            rdata_d = bus_rdata;
          req_d   = 1'b0;
          state_d = DONE;
        end
`ifdef BUS_TIMEOUT_EN
        else if (to_hit) begin
          rdata_d = DATA_W'(ERR_DATA);
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      mis_q   <= mis_d;
`ifdef BUS_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  // Stall is raised in the request cycle itself and released in DONE.
  assign StallMem  = rst && (accept || (state_q == WAIT));
  assign ReadDataM = rdata_q;
  assign MisalignM = mis_q;
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
`ifdef BUS_TIMEOUT_EN
  assign BusErr    = err_q;
`endif

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed self-checking bench for mem_bus_ctrl.
// Adds the watchdog scenario when built with BUS_TIMEOUT_EN.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM;
  logic [31:0] ALUOutM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallMem, MisalignM;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ack;
`ifdef BUS_TIMEOUT_EN
  logic        BusErr;
`endif

  int tests = 0;
  int fails = 0;
  int rises = 0;
  logic req_prev = 1'b0;

  always #5 clk = ~clk;

  mem_bus_ctrl #(
    .ADDR_W  (32),
    .DATA_W  (32)
`ifdef BUS_TIMEOUT_EN
    ,
    .TIMEOUT (4)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallMem   (StallMem),
    .MisalignM  (MisalignM),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack)
`ifdef BUS_TIMEOUT_EN
    ,
    .BusErr     (BusErr)
`endif
  );

  always @(posedge clk) begin
    if (bus_req && !req_prev)
      rises++;
    req_prev <= bus_req;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    MemReadM = 0; MemWriteM = 0;
    ALUOutM = 0; WriteDataM = 0;
    bus_rdata = 0; bus_ack = 0;

    step; step;
    @(negedge clk);
    chk("rst_stall", 32'(StallMem), 32'd0);
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_we", 32'(bus_we), 32'd0);
    chk("rst_mis", 32'(MisalignM), 32'd0);
    chk("rst_rdata", ReadDataM, 32'h0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    step;
    rst = 1'b1;

    // Load 0x40, ack in third WAIT cycle
    step;
    MemReadM = 1; ALUOutM = 32'h40;
    @(negedge clk);
    chk("ld_c0_stall", 32'(StallMem), 32'd1);
    chk("ld_c0_req", 32'(bus_req), 32'd0);
    step;
    @(negedge clk);
    chk("ld_c1_stall", 32'(StallMem), 32'd1);
    chk("ld_c1_req", 32'(bus_req), 32'd1);
    chk("ld_we", 32'(bus_we), 32'd0);
    chk("ld_addr", bus_addr, 32'h40);
    step;
    @(negedge clk);
    chk("ld_c2_stall", 32'(StallMem), 32'd1);
    step;
    bus_ack = 1; bus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("ld_c3_stall", 32'(StallMem), 32'd1);
    step;
    bus_ack = 0; bus_rdata = 32'h0;
    @(negedge clk);
    chk("ld_done_stall", 32'(StallMem), 32'd0);
    chk("ld_done_req", 32'(bus_req), 32'd0);
    chk("ld_rdata", ReadDataM, 32'hDEADBEEF);
    step;
    MemReadM = 0;
    @(negedge clk);
    chk("ld_idle_req", 32'(bus_req), 32'd0);
    chk("ld_idle_stall", 32'(StallMem), 32'd0);

    // Ack outside WAIT is ignored
    bus_ack = 1; bus_rdata = 32'h0BAD0BAD;
    step;
    bus_ack = 0;
    @(negedge clk);
    chk("stray_ack_rdata", ReadDataM, 32'hDEADBEEF);
    chk("stray_ack_req", 32'(bus_req), 32'd0);

    // Store 0x10, immediate ack
    MemWriteM = 1; ALUOutM = 32'h10; WriteDataM = 32'h12345678;
    @(negedge clk);
    chk("st_c0_stall", 32'(StallMem), 32'd1);
    step;
    bus_ack = 1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("st_c1_stall", 32'(StallMem), 32'd1);
    chk("st_req", 32'(bus_req), 32'd1);
    chk("st_we", 32'(bus_we), 32'd1);
    chk("st_addr", bus_addr, 32'h10);
    chk("st_wdata", bus_wdata, 32'h12345678);
    step;
    bus_ack = 0;
    @(negedge clk);
    chk("st_done_stall", 32'(StallMem), 32'd0);
    chk("st_done_req", 32'(bus_req), 32'd0);
    chk("st_rdata_keep", ReadDataM, 32'hDEADBEEF);
    step;
    MemWriteM = 0;

    // Misaligned load
    MemReadM = 1; ALUOutM = 32'h41;
    @(negedge clk);
    chk("mis_stall", 32'(StallMem), 32'd0);
    chk("mis_c0_pulse", 32'(MisalignM), 32'd0);
    step;
    MemReadM = 0;
    @(negedge clk);
    chk("mis_pulse", 32'(MisalignM), 32'd1);
    chk("mis_rdata", ReadDataM, 32'h0);
    chk("mis_req", 32'(bus_req), 32'd0);
    step;
    @(negedge clk);
    chk("mis_pulse_end", 32'(MisalignM), 32'd0);

    // Back-to-back load then store
    MemReadM = 1; ALUOutM = 32'h80;
    step;
    bus_ack = 1; bus_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    chk("b2b_ld_req", 32'(bus_req), 32'd1);
    chk("b2b_ld_we", 32'(bus_we), 32'd0);
    step;
    bus_ack = 0;
    @(negedge clk);
    chk("b2b_done_stall", 32'(StallMem), 32'd0);
    chk("b2b_done_req", 32'(bus_req), 32'd0);
    step;
    MemReadM = 0; MemWriteM = 1;
    ALUOutM = 32'h84; WriteDataM = 32'h00000055;
    @(negedge clk);
    chk("b2b_st_c0_stall", 32'(StallMem), 32'd1);
    chk("b2b_st_c0_req", 32'(bus_req), 32'd0);
    step;
    bus_ack = 1;
    @(negedge clk);
    chk("b2b_st_req", 32'(bus_req), 32'd1);
    chk("b2b_st_we", 32'(bus_we), 32'd1);
    chk("b2b_st_addr", bus_addr, 32'h84);
    step;
    bus_ack = 0;
    @(negedge clk);
    chk("b2b_rdata", ReadDataM, 32'hA5A5A5A5);
    step;
    MemWriteM = 0;
    step;
    chk("req_rises", 32'(rises), 32'd4);

`ifdef BUS_TIMEOUT_EN
    // No ack: watchdog aborts after four WAIT cycles
    MemReadM = 1; ALUOutM = 32'h20;
    step;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_wait_req", 32'(bus_req), 32'd1);
      step;
    end
    @(negedge clk);
    chk("to_done_req", 32'(bus_req), 32'd0);
    chk("to_done_stall", 32'(StallMem), 32'd0);
    chk("to_rdata", ReadDataM, 32'hFFFFFFFF);
    chk("to_buserr", 32'(BusErr), 32'd1);
    step;
    MemReadM = 0;
    step; step;
    @(negedge clk);
    chk("to_buserr_sticky", 32'(BusErr), 32'd1);
`endif

    // Reset mid-WAIT
    MemReadM = 1; ALUOutM = 32'h44;
    step;
    step;
    @(negedge clk);
    chk("rw_pre_req", 32'(bus_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rw_req", 32'(bus_req), 32'd0);
    chk("rw_stall", 32'(StallMem), 32'd0);
    chk("rw_rdata", ReadDataM, 32'h0);
`ifdef BUS_TIMEOUT_EN
    chk("rw_buserr", 32'(BusErr), 32'd0);
`endif
    MemReadM = 0;
    step;
    rst = 1'b1;
    step;
    @(negedge clk);
    chk("rw_after_req", 32'(bus_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Multi-cycle data-memory controller placed directly downstream of the MEM stage.
- Replaces the single-cycle data memory: accepts load/store requests from the EX/MEM register outputs and runs a req/ack transaction on an external memory bus.
- Returns load data to the MEM/WB register.
- Drives StallMem so the hazard logic freezes the pipeline for the duration of the transaction.

Parameters:
- ADDR_W, 32, byte-address width on the pipeline side and the bus side.
- DATA_W, 32, data width. Word accesses only.
- TIMEOUT, 255, maximum WAIT cycles before abort. Used only with BUS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- MemReadM  in  1  load request in MEM (MemtoRegM).
- MemWriteM  in  1  store request in MEM.
- ALUOutM  in  ADDR_W  byte address.
- WriteDataM  in  DATA_W  store data.
- ReadDataM  out  DATA_W  registered load data.
- StallMem  out  1  pipeline hold request, to HazardUnit.
- MisalignM  out  1  one-cycle pulse: misaligned access dropped.
- bus_req  out  1  transaction request.
- bus_we  out  1  1 = write, 0 = read.
- bus_addr  out  ADDR_W  word-aligned address.
- bus_wdata  out  DATA_W  write data.
- bus_rdata  in  DATA_W  read data, valid when bus_ack = 1.
- bus_ack  in  1  one-cycle completion strobe.

Behaviour:
- Reset (rst = 0, asynchronous):
  - State goes to IDLE.
  - ReadDataM, bus_addr, bus_wdata reset to 0.
  - bus_req, bus_we, MisalignM reset to 0.
  - StallMem reads 0.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - With MemReadM or MemWriteM = 1 and ALUOutM[1:0] = 0:
    - Latch address, data and direction.
    - Go to WAIT.
    - StallMem = 1 combinationally in this same cycle.
  - Both MemReadM and MemWriteM = 1: treated as a write.
  - ALUOutM[1:0] != 0:
    - No bus access and no stall.
    - MisalignM = 1 for the next cycle only.
    - ReadDataM is loaded with 0.
- WAIT:
  - bus_req = 1; bus_we, bus_addr, bus_wdata are stable.
  - StallMem = 1.
  - On bus_ack = 1:
    - If read, ReadDataM <= bus_rdata.
    - bus_req drops on the next edge.
    - Go to DONE.
- DONE:
  - StallMem = 0 for exactly one cycle so the pipeline advances past the instruction.
  - New requests are ignored during DONE, so the completed instruction cannot retrigger.
  - Go to IDLE.
- Minimum latency for a stalled access: request seen in cycle 0, bus_req rises in cycle 1.
  - Ack in cycle 1 gives DONE in cycle 2 and a total of 3 cycles.
- Stores leave ReadDataM unchanged.
- bus_ack outside WAIT is ignored.
- A reset during WAIT aborts the transaction immediately: bus_req = 0 with no completion.
- ReadDataM holds its value until the next load completes.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- When defined:
  - An 8-bit-plus counter clears on entry to WAIT and increments each WAIT cycle.
  - When the count reaches TIMEOUT with no ack: drop bus_req, go to DONE, ReadDataM <= all ones.
  - Sticky output port BusErr (1 bit, reset 0) is set and cleared only by reset.
- When undefined: no counter, no BusErr port, and WAIT lasts indefinitely.

Decomposition:
- Shared package mips_pkg holds:
  - The state typedef (IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2).
  - Constants WORD_ALIGN_MASK = 2'b11 and ERR_DATA = 32'hFFFF_FFFF.
- Optional sub-module: bus_timeout_cnt, holding the watchdog counter and its compare.
  - Instantiated only under BUS_TIMEOUT_EN.

Test Plan:
- Reset: drive rst = 0 mid-WAIT with bus_req = 1 -> bus_req = 0, StallMem = 0, ReadDataM = 0 immediately.
- Load: MemReadM = 1, ALUOutM = 0x40, ack after 3 WAIT cycles with bus_rdata = 0xDEADBEEF:
  - StallMem = 1 for 4 cycles, then 0 for one DONE cycle.
  - ReadDataM = 0xDEADBEEF; bus_we = 0; bus_addr = 0x40.
- Store: MemWriteM = 1, ALUOutM = 0x10, WriteDataM = 0x12345678, immediate ack:
  - bus_we = 1, bus_wdata = 0x12345678.
  - ReadDataM unchanged; total stall of 2 cycles.
- Misaligned: MemReadM = 1, ALUOutM = 0x41 -> no bus_req, StallMem = 0, MisalignM pulses once, ReadDataM = 0.
- Back-to-back: load then store in consecutive instructions -> two separate transactions, exactly one DONE cycle between them, no duplicate bus_req.
- BUS_TIMEOUT_EN, TIMEOUT = 4, no ack:
  - Abort after 4 WAIT cycles with ReadDataM = 0xFFFFFFFF.
  - BusErr = 1 and stays 1 until reset.
